// File: rtl/cpu_bus_target.sv
// cpu_bus_target
//   Responder side of the CPU bus. It decodes each CPU address and returns
//   registered read data or accepts write data. It hosts:
//     - 2^RAM_AW bytes of work RAM, mirrored through $0000-$1FFF
//     - the serial controller ports at $4016 and $4017
//     - a pass-through to external PRG ROM at $8000-$FFFF
//     - an open-bus latch: unmapped reads leave rdata unchanged
//
//   Build option: define JOYPAD2_EN to serve $4017 from pad2. Without it,
//   $4017 behaves as open bus and the second shift register is not built.
//
// Ports
//   clk       system clock, all state updates on posedge
//   rst       asynchronous active-low reset
//   addr      CPU address bus
//   wdata     CPU write data
//   write     1 = write cycle, 0 = read cycle
//   rdata     registered read data to the CPU data input
//   pad1      controller 1 buttons, bit0..7 = A,B,Select,Start,Up,Down,Left,Right
//   pad2      controller 2 buttons, same order
//   prg_addr  PRG ROM address, addr[14:0]
//   prg_data  PRG ROM data, valid in the same cycle as prg_addr
module cpu_bus_target #(
    parameter int RAM_AW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        write,
    output logic [7:0]  rdata,
    input  logic [7:0]  pad1,
    input  logic [7:0]  pad2,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_data
);

    logic [7:0] ram [0:(1 << RAM_AW) - 1];

    logic       sel_ram;
    logic       sel_pad1;
    logic       sel_rom;
    logic       rd_pad1;
    logic       strobe;
    logic [7:0] sr1;
    logic       prev_rd1;
    logic       pad1_bit;

    assign prg_addr = addr[14:0];
    assign sel_ram  = (addr[15:13] == 3'b000);
    assign sel_pad1 = (addr == 16'h4016);
    assign sel_rom  = addr[15];
    assign rd_pad1  = sel_pad1 && !write;

    // While strobe is high the register is being reloaded every cycle, so
    // return the live A button instead of the previous cycle's snapshot.
    assign pad1_bit = strobe ? pad1[0] : sr1[0];

`ifdef JOYPAD2_EN
    logic       sel_pad2;
    logic       rd_pad2;
    logic [7:0] sr2;
    logic       prev_rd2;
    logic       pad2_bit;

    assign sel_pad2 = (addr == 16'h4017);
    assign rd_pad2  = sel_pad2 && !write;
    assign pad2_bit = strobe ? pad2[0] : sr2[0];
`else
    logic unused_pad2;
    assign unused_pad2 = ^pad2;
`endif

    // Work RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (write && sel_ram)
            ram[addr[RAM_AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata    <= '0;
            strobe   <= 1'b0;
            sr1      <= '0;
            prev_rd1 <= 1'b0;
`ifdef JOYPAD2_EN
            sr2      <= '0;
            prev_rd2 <= 1'b0;
`endif
        end else begin
            if (write && sel_pad1)
                strobe <= wdata[0];

            // Shift only on the first cycle of a contiguous read of the port;
            // the CPU may hold the address for several cycles.
            if (strobe)
                sr1 <= pad1;
            else if (rd_pad1 && !prev_rd1)
                sr1 <= {1'b1, sr1[7:1]};
            prev_rd1 <= rd_pad1;

`ifdef JOYPAD2_EN
            if (strobe)
                sr2 <= pad2;
            else if (rd_pad2 && !prev_rd2)
                sr2 <= {1'b1, sr2[7:1]};
            prev_rd2 <= rd_pad2;
`endif

            // Unmapped reads and all write cycles leave rdata untouched.
            if (!write) begin
                if (sel_ram)
                    rdata <= ram[addr[RAM_AW-1:0]];
                else if (sel_pad1)
                    rdata <= {7'b0100_000, pad1_bit};
`ifdef JOYPAD2_EN
                else if (sel_pad2)
                    rdata <= {7'b0100_000, pad2_bit};
`endif
                else if (sel_rom)
                    rdata <= prg_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_target.sv
// Testbench for cpu_bus_target: directed scenarios followed by randomized bus
// traffic, all checked against a behavioural model of the bus map, the
// controller protocol (strobe, bit order, count of serial reads) and open bus.
module tb_cpu_bus_target;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        write = 1'b0;
    logic [7:0]  rdata;
    logic [7:0]  pad1 = '0;
    logic [7:0]  pad2 = '0;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;

    int checks = 0;
    int errors = 0;

    cpu_bus_target #(.RAM_AW(11)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .write    (write),
        .rdata    (rdata),
        .pad1     (pad1),
        .pad2     (pad2),
        .prg_addr (prg_addr),
        .prg_data (prg_data)
    );

    always #5 clk = ~clk;

    // External ROM contents: a fixed function of the ROM address.
    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ {1'b0, a[14:8]};
    endfunction

    assign prg_data = rom({1'b1, prg_addr});

    // Reference model state
    logic [7:0] mem [0:2047];
    logic [7:0] exp_r    = '0;
    bit         strobe_m = 1'b0;
    logic [7:0] load1 = '0, load2 = '0;
    int         cnt1 = 0, cnt2 = 0;   // serial reads done since last load
    bit         last_rd1 = 1'b0, last_rd2 = 1'b0;

    function automatic bit ser_bit(input logic [7:0] snap, input int n);
        if (n >= 8) return 1'b1;
        return snap[n];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_r = '0; strobe_m = 1'b0; load1 = '0; load2 = '0;
        cnt1 = 0; cnt2 = 0; last_rd1 = 1'b0; last_rd2 = 1'b0;
    endtask

    // One bus cycle; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic [15:0] a, input logic w, input logic [7:0] wd);
        bit nxt_strobe;
        addr = a; write = w; wdata = wd;
        #1;
        chk("prg_addr", {1'b0, prg_addr}, {1'b0, a[14:0]});
        if (!w) begin
            if (a < 16'h2000)
                exp_r = mem[a[10:0]];
            else if (a == 16'h4016) begin
                exp_r = 8'h40 | (strobe_m ? pad1[0] : ser_bit(load1, cnt1));
                if (!strobe_m && !last_rd1) cnt1++;
            end
`ifdef JOYPAD2_EN
            else if (a == 16'h4017) begin
                exp_r = 8'h40 | (strobe_m ? pad2[0] : ser_bit(load2, cnt2));
                if (!strobe_m && !last_rd2) cnt2++;
            end
`endif
            else if (a >= 16'h8000)
                exp_r = rom(a);
        end
        nxt_strobe = strobe_m;
        if (w && a < 16'h2000) mem[a[10:0]] = wd;
        if (w && a == 16'h4016) nxt_strobe = wd[0];
        if (strobe_m) begin
            load1 = pad1; cnt1 = 0; load2 = pad2; cnt2 = 0;
        end
        last_rd1 = !w && a == 16'h4016;
        last_rd2 = !w && a == 16'h4017;
        strobe_m = nxt_strobe;
        @(posedge clk);
        #1;
        chk("rdata", {8'h00, rdata}, {8'h00, exp_r});
    endtask

    function automatic logic [15:0] open_addr();
        case ($urandom_range(0, 2))
            0:       return 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
            1:       return 16'h4000 + 16'($urandom_range(0, 16'h15));
            default: return 16'h4018 + 16'($urandom_range(0, 16'h3FE7));
        endcase
    endfunction

    logic [7:0] ctl_exp [10];
    logic [7:0] saved;
    logic [15:0] la, ra;
    logic        lw;

    initial begin
        ctl_exp = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};

        // Reset state
        #2;
        chk("reset_rdata", {8'h00, rdata}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();

        // Initialise every RAM byte through random mirrors
        for (int i = 0; i < 2048; i++)
            step(16'(i) | (16'($urandom_range(0, 3)) << 11), 1'b1, 8'($urandom));

        // RAM mirror
        step(16'h0123, 1'b1, 8'hA5);
        step(16'h0923, 1'b0, 8'h00); chk("mirror_0923", {8'h00, rdata}, 16'h00A5);
        step(16'h1123, 1'b0, 8'h00); chk("mirror_1123", {8'h00, rdata}, 16'h00A5);
        step(16'h1923, 1'b0, 8'h00); chk("mirror_1923", {8'h00, rdata}, 16'h00A5);

        // Controller serial read, separated accesses
        pad1 = 8'b0000_1001;
        step(16'h4016, 1'b1, 8'h01);
        step(16'h4016, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(16'h4016, 1'b0, 8'h00);
            chk("pad1_serial", {8'h00, rdata}, {8'h00, ctl_exp[i]});
            step(16'h0000, 1'b0, 8'h00);
        end

        // Held address: one shift only
        pad1 = 8'b0000_0010;
        step(16'h4016, 1'b1, 8'h01);
        step(16'h4016, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(16'h4016, 1'b0, 8'h00);
        step(16'h5000, 1'b0, 8'h00);
        step(16'h4016, 1'b0, 8'h00);
        chk("held_bit1", {8'h00, rdata}, 16'h0041);

        // Strobe written then read at once: fresh pad bit0
        pad1 = 8'h01;
        step(16'h4016, 1'b1, 8'h01);
        step(16'h4016, 1'b0, 8'h00);
        chk("strobe_read", {8'h00, rdata}, 16'h0041);
        step(16'h4016, 1'b1, 8'h00);

        // Open bus and ROM write
        step(16'h0010, 1'b1, 8'h3C);
        step(16'h0010, 1'b0, 8'h00); chk("ram_3c", {8'h00, rdata}, 16'h003C);
        step(16'h5000, 1'b0, 8'h00); chk("open_bus", {8'h00, rdata}, 16'h003C);
        step(16'h8000, 1'b1, 8'hFF); chk("write_hold", {8'h00, rdata}, 16'h003C);
        step(16'h8000, 1'b0, 8'h00); chk("rom_8000", {8'h00, rdata}, {8'h00, rom(16'h8000)});
        step(16'hC37A, 1'b0, 8'h00); chk("rom_c37a", {8'h00, rdata}, {8'h00, rom(16'hC37A)});

        // Controller 2
        pad2 = 8'h01;
        step(16'h0010, 1'b0, 8'h00);
        step(16'h4016, 1'b1, 8'h01);
        step(16'h4016, 1'b1, 8'h00);
        step(16'h4017, 1'b0, 8'h00);
`ifdef JOYPAD2_EN
        chk("pad2_first", {8'h00, rdata}, 16'h0041);
`else
        chk("pad2_first", {8'h00, rdata}, 16'h003C);
`endif

        // Reset mid-run while $4016 is being read, with strobe previously set
        pad1 = 8'hFF;
        step(16'h4016, 1'b1, 8'h01);
        step(16'h4016, 1'b0, 8'h00);
        rst = 1'b0;
        #1;
        chk("async_reset", {8'h00, rdata}, 16'h0000);
        model_reset();
        @(posedge clk); #1;
        chk("reset_hold", {8'h00, rdata}, 16'h0000);
        rst = 1'b1;
        step(16'h4016, 1'b0, 8'h00);
        chk("post_reset_4016", {8'h00, rdata}, 16'h0040);
        step(16'h6000, 1'b0, 8'h00);
        chk("post_reset_open", {8'h00, rdata}, 16'h0040);

        // Randomized traffic
        la = 16'h0000; lw = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                pad1 = 8'($urandom);
                pad2 = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0 && !lw) begin
                step(la, 1'b0, 8'($urandom));
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2: begin ra = 16'($urandom_range(0, 16'h1FFF)); lw = 1'b0; end
                    3:       begin ra = 16'($urandom_range(0, 16'h1FFF)); lw = 1'b1; end
                    4:       begin ra = 16'h4016; lw = 1'b0; end
                    5:       begin ra = 16'h4016; lw = 1'b1; end
                    6:       begin ra = 16'h4017; lw = 1'b0; end
                    7:       begin ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF)); lw = 1'b0; end
                    8:       begin ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF)); lw = 1'b1; end
                    default: begin ra = open_addr(); lw = 1'($urandom_range(0, 1)); end
                endcase
                la = ra;
                step(ra, lw, 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_target.md
# cpu_bus_target

Responder side of the CPU bus: decodes every address the CPU drives and returns registered read data or accepts write data. It hosts the 2 KB internal work RAM (mirrored across $0000-$1FFF), the serial controller ports at $4016/$4017, a pass-through to external PRG ROM at $8000-$FFFF and an open-bus latch for unmapped space. It sits between the CPU core and the rest of the console, driving the CPU's data input.

## Interface
- RAM_AW, 11, work-RAM address width; RAM depth 2^RAM_AW bytes, mirrored through $0000-$1FFF

- clk  input  1  system clock, all state on posedge
- rst  input  1  reset; asynchronous, active-low
- addr  input  16  CPU address bus
- wdata  input  8  CPU write data
- write  input  1  1 = write cycle, 0 = read cycle
- rdata  output  8  registered read data to CPU data input
- pad1  input  8  controller 1 buttons, bit0..7 = A,B,Select,Start,Up,Down,Left,Right, 1 = pressed
- pad2  input  8  controller 2 buttons, same order
- prg_addr  output  15  PRG ROM address, = addr[14:0] combinationally
- prg_data  input  8  PRG ROM data, valid same cycle as prg_addr

## Operation
- Decode (addr, write=0):
  - $0000-$1FFF: RAM[addr[RAM_AW-1:0]]
  - $4016: {8'h40 | pad1_bit}
  - $4017: {8'h40 | pad2_bit}
  - $8000-$FFFF: prg_data
  - else (including $2000-$3FFF, owned by another block): open bus, rdata holds its current value
- Writes (write=1):
  - $0000-$1FFF: RAM[addr[RAM_AW-1:0]] <= wdata
  - $4016: strobe <= wdata[0]
  - all else ignored, including ROM
  - rdata holds during write cycles
- Controller shift registers sr1, sr2 (8 bit):
  - While strobe=1: reload from pad1/pad2 every cycle; the bit returned is bit0 (A).
  - strobe 1->0: last loaded value retained.
  - Read of $4016 with strobe=0: return sr1[0]; sr1 <= {1'b1, sr1[7:1]}. $4017 likewise for sr2.
  - After 8 shifts, reads return 1.
- Read side effect fires once per access. The CPU may hold an address for several cycles, so a shift happens only on the first cycle of a contiguous run with addr=$4016 (or $4017) and write=0. This is detected with a registered previous-cycle match flag.
- RAM contents are not reset.

## Timing
- Read latency 1: addr presented in cycle N, rdata valid after posedge ending N, stable through N+1.
- Write commits at the posedge ending the write cycle. A read of the same address in the next cycle returns the new data.
- Reset values (asserted asynchronously, held while rst=0):
  - rdata = 8'h00
  - strobe = 0
  - sr1 = sr2 = 8'h00
  - previous-match flags = 0
- Reset mid-run on $4016: after release, the first cycle counts as a new access and shifts once.
- Write to $4016 with wdata[0]=1 and an immediate read: the read returns the freshly loaded pad bit0.
- Open-bus reads keep rdata from the last mapped read. After reset, that value is 8'h00.

## Configuration
- JOYPAD2_EN:
  - Defined: $4017 is served by pad2/sr2 as above.
  - Undefined: pad2 is ignored, sr2 is not built, and $4017 reads behave as open bus.

## Test plan
- RAM mirror: write 8'hA5 to $0123, then read $0923, $1123 and $1923 -> each returns 8'hA5 one cycle after its address.
- Controller serial read: pad1=8'b0000_1001, write $4016=1 then $4016=0, then 10 separate reads of $4016 -> rdata = $41,$40,$40,$41,$40,$40,$40,$40,$41,$41.
- Held address: addr=$4016, write=0 held for 4 cycles -> exactly one shift; a following separate read returns the bit1 value.
- Open bus: read $0010 (=8'h3C), then read $5000 -> rdata stays 8'h3C. Write $8000=8'hFF -> no effect; read $8000 returns prg_data.
- Reset: assert rst=0 mid-sequence -> rdata=8'h00 immediately, strobe=0. Post-reset $4016 read returns 8'h40.
- JOYPAD2_EN: pad2=8'h01 after strobe. Defined -> the first $4017 read returns 8'h41. Undefined -> it returns the prior rdata.
